gcn_fm_wm_adj_row_reader: RTL



---
 rtl/gcn_fm_wm_adj_row_reader.sv | 119 +++++++++++
 1 files changed

// File: rtl/gcn_fm_wm_adj_row_reader.sv
// Read-side controller for the accumulated FM x WM x ADJ result memory:
// walks the rows, registers each row, finds its argmax and streams it out.
module gcn_fm_wm_adj_row_reader #(
  parameter int unsigned FEATURE_ROWS   = 6,
  parameter int unsigned WEIGHT_COLS    = 3,
  parameter int unsigned DOT_PROD_WIDTH = 16,
  parameter int unsigned FEATURE_WIDTH  = $clog2(FEATURE_ROWS),
  parameter int unsigned WEIGHT_WIDTH   = $clog2(WEIGHT_COLS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  output logic [FEATURE_WIDTH-1:0]  read_row,
  input  logic [DOT_PROD_WIDTH-1:0] mem_row_in [0:WEIGHT_COLS-1],
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FEATURE_WIDTH-1:0]  out_row_idx,
  output logic [DOT_PROD_WIDTH-1:0] out_data [0:WEIGHT_COLS-1],
  output logic [WEIGHT_WIDTH-1:0]   out_argmax,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned COL_W = (WEIGHT_WIDTH < 1) ? 1 : WEIGHT_WIDTH;

  typedef enum logic [2:0] {IDLE, FETCH, SCAN, HOLD, DONE} state_t;

  state_t                    state;
  logic [FEATURE_WIDTH-1:0]  row_cnt;
  logic [COL_W-1:0]          col;
  logic [DOT_PROD_WIDTH-1:0] max_val;

  // Row counter doubles as the memory address and the presented row index.
  assign read_row    = row_cnt;
  assign out_row_idx = row_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row_cnt    <= '0;
      col        <= '0;
      max_val    <= '0;
      out_argmax <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int i = 0; i < int'(WEIGHT_COLS); i++) out_data[i] <= '0;
    end else if (state != IDLE && abort) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row_cnt <= '0;
            busy    <= 1'b1;
            state   <= FETCH;
          end
        end

        FETCH: begin
          for (int i = 0; i < int'(WEIGHT_COLS); i++) out_data[i] <= mem_row_in[i];
          max_val    <= mem_row_in[0];
          out_argmax <= '0;
          col        <= COL_W'(1);
          if (WEIGHT_COLS == 1) begin
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            state <= SCAN;
          end
        end

        // Strictly-greater update keeps the lowest index on ties.
        SCAN: begin
          if (out_data[col] > max_val) begin
            max_val    <= out_data[col];
            out_argmax <= WEIGHT_WIDTH'(col);
          end
          col <= col + COL_W'(1);
          if (col == COL_W'(WEIGHT_COLS - 1)) begin
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end

        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (row_cnt == FEATURE_WIDTH'(FEATURE_ROWS - 1)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              row_cnt <= row_cnt + FEATURE_WIDTH'(1);
              state   <= FETCH;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
